// File: rtl/irq_controller.sv
// irq_controller: fixed-priority interrupt controller with masked sticky pending bits; define IRQC_LEVEL_EN for level-sensitive sources
module irq_controller #(
  parameter int N_SRC = 4,
  parameter int ID_W = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic [N_SRC-1:0] src_irq,
  input  logic PCK,
  input  logic eret,
  input  logic wr_en,
  input  logic rd_en,
  input  logic [1:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic IRQ,
  output logic [ID_W-1:0] irq_id
);
  typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;
  state_t state;
  logic [N_SRC-1:0] mask, pend, eligible, sel;
  logic [ID_W-1:0] winner;
  logic take;
  logic [31:0] status, rd_mux;
  logic unused_wr;
  assign unused_wr = ^wr_data[31:N_SRC];
  assign eligible = pend & mask;
  assign sel = N_SRC'(1) << irq_id;
  assign take = state == REQ && !PCK;
  assign status = {state == SVC, state == REQ, {(30-ID_W){1'b0}}, irq_id};
  // lowest set eligible index wins
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) winner = eligible[i] ? ID_W'(i) : winner;
  end
  // read mux sees pre-write state so a same-cycle read returns the old value
  always_comb rd_mux = addr == 2'd0 ? 32'(mask) : addr == 2'd1 ? 32'(pend) : addr == 2'd2 ? status : 32'd0;
  // mask register and registered read data
  always_ff @(posedge clk)
    if (reset) begin
      mask <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en && addr == 2'd0) mask <= wr_data[N_SRC-1:0];
      if (rd_en) rd_data <= rd_mux;
    end
`ifdef IRQC_LEVEL_EN
  // pending bits follow the request lines; software and the take cannot clear them
  always_ff @(posedge clk) pend <= reset ? '0 : src_irq;
`else
  logic [N_SRC-1:0] prev, clr;
  assign clr = (wr_en && addr == 2'd1 ? wr_data[N_SRC-1:0] : '0) | (take ? sel : '0);
  // sticky pending bits: a new rising edge beats any clear landing on the same edge
  always_ff @(posedge clk)
    if (reset) begin
      pend <= '0;
      prev <= '0;
    end else begin
      pend <= (pend & ~clr) | (src_irq & ~prev);
      prev <= src_irq;
    end
`endif
  // one interrupt in flight: request, taken in user mode, serviced until eret
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      IRQ <= 1'b0;
      irq_id <= '0;
    end else
      case (state)
        IDLE:
          if (|eligible) begin
            state <= REQ;
            IRQ <= 1'b1;
            irq_id <= winner;
          end
        REQ:
          if (!PCK) begin
            state <= SVC;
            IRQ <= 1'b0;
          end else if (~|(eligible & sel)) begin
            state <= IDLE;
            IRQ <= 1'b0;
          end
        SVC: if (eret) state <= IDLE;
        default: begin
          state <= IDLE;
          IRQ <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed self-checking bench for irq_controller (edge-triggered build)
module tb_irq_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] src_irq = '0;
  logic PCK = 1'b0;
  logic eret = 1'b0;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;
  logic [1:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic IRQ;
  logic [2:0] irq_id;
  int total = 0;
  int bad = 0;

  irq_controller #(.N_SRC(4), .ID_W(3)) dut (
    .clk(clk), .reset(reset), .src_irq(src_irq), .PCK(PCK), .eret(eret),
    .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .IRQ(IRQ), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a);
    rd_en = 1'b1; addr = a;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic pulse_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", IRQ); end
    total++; if (irq_id !== 3'd0) begin bad++; $display("FAIL reset_id got=%0d exp=0", irq_id); end
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd got=%h exp=0", rd_data); end
    bus_rd(2'd0);
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset_mask got=%h exp=0", rd_data); end
    bus_rd(2'd1);
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset_pend got=%h exp=0", rd_data); end
    bus_rd(2'd2);
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=0", rd_data); end
  endtask

  task automatic test_basic();
    bus_wr(2'd0, 32'hF);
    src_irq = 4'b0100;
    tick();
    src_irq = 4'b0000;
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL basic_lat1 got=%b exp=0", IRQ); end
    tick();
    total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL basic_irq got=%b exp=1", IRQ); end
    total++; if (irq_id !== 3'd2) begin bad++; $display("FAIL basic_id got=%0d exp=2", irq_id); end
    tick();
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL basic_take got=%b exp=0", IRQ); end
    bus_rd(2'd2);
    total++; if (rd_data !== 32'h8000_0002) begin bad++; $display("FAIL basic_status got=%h exp=80000002", rd_data); end
    bus_rd(2'd1);
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL basic_pend got=%h exp=0", rd_data); end
    pulse_eret();
    bus_rd(2'd2);
    total++; if (rd_data !== 32'h0000_0002) begin bad++; $display("FAIL basic_idle got=%h exp=00000002", rd_data); end
  endtask

  task automatic test_priority();
    src_irq = 4'b1010;
    tick();
    src_irq = 4'b0000;
    tick();
    total++; if (IRQ !== 1'b1 || irq_id !== 3'd1) begin bad++; $display("FAIL prio_first got=%b/%0d exp=1/1", IRQ, irq_id); end
    tick();
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL prio_take got=%b exp=0", IRQ); end
    bus_rd(2'd1);
    total++; if (rd_data !== 32'h8) begin bad++; $display("FAIL prio_pend got=%h exp=8", rd_data); end
    pulse_eret();
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL prio_idle got=%b exp=0", IRQ); end
    tick();
    total++; if (IRQ !== 1'b1 || irq_id !== 3'd3) begin bad++; $display("FAIL prio_second got=%b/%0d exp=1/3", IRQ, irq_id); end
    tick();
    pulse_eret();
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL prio_done got=%b exp=0", IRQ); end
  endtask

  task automatic test_mask();
    bus_wr(2'd0, 32'h0);
    src_irq = 4'b0001;
    tick();
    src_irq = 4'b0000;
    tick(); tick();
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL mask_block got=%b exp=0", IRQ); end
    bus_rd(2'd1);
    total++; if (rd_data !== 32'h1) begin bad++; $display("FAIL mask_pend got=%h exp=1", rd_data); end
    bus_wr(2'd0, 32'h1);
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL mask_lat got=%b exp=0", IRQ); end
    PCK = 1'b1;
    tick();
    total++; if (IRQ !== 1'b1 || irq_id !== 3'd0) begin bad++; $display("FAIL mask_irq got=%b/%0d exp=1/0", IRQ, irq_id); end
  endtask

  task automatic test_kernel_hold();
    rd_en = 1'b1; addr = 2'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (IRQ !== 1'b1 || rd_data !== 32'h4000_0000) begin bad++; $display("FAIL hold_%0d got=%b/%h exp=1/40000000", i, IRQ, rd_data); end
    end
    PCK = 1'b0;
    tick();
    total++; if (IRQ !== 1'b0 || rd_data !== 32'h4000_0000) begin bad++; $display("FAIL hold_take got=%b/%h exp=0/40000000", IRQ, rd_data); end
    tick();
    total++; if (rd_data !== 32'h8000_0000) begin bad++; $display("FAIL hold_svc got=%h exp=80000000", rd_data); end
    rd_en = 1'b0;
    pulse_eret();
  endtask

  task automatic test_w1c();
    bus_wr(2'd0, 32'hF);
    PCK = 1'b1;
    src_irq = 4'b0100;
    tick();
    src_irq = 4'b0000;
    tick();
    total++; if (IRQ !== 1'b1 || irq_id !== 3'd2) begin bad++; $display("FAIL w1c_req got=%b/%0d exp=1/2", IRQ, irq_id); end
    bus_wr(2'd1, 32'h4);
    total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL w1c_lat got=%b exp=1", IRQ); end
    tick();
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL w1c_drop got=%b exp=0", IRQ); end
    src_irq = 4'b0100; wr_en = 1'b1; addr = 2'd1; wr_data = 32'h4;
    tick();
    src_irq = 4'b0000; wr_en = 1'b0;
    bus_rd(2'd1);
    total++; if (rd_data !== 32'h4) begin bad++; $display("FAIL w1c_setwins got=%h exp=4", rd_data); end
    total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL w1c_rereq got=%b exp=1", IRQ); end
    PCK = 1'b0; src_irq = 4'b0100;
    tick();
    src_irq = 4'b0000;
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL take_set got=%b exp=0", IRQ); end
    bus_rd(2'd1);
    total++; if (rd_data !== 32'h4) begin bad++; $display("FAIL take_setwins got=%h exp=4", rd_data); end
    pulse_eret();
    tick();
    total++; if (IRQ !== 1'b1 || irq_id !== 3'd2) begin bad++; $display("FAIL take_rereq got=%b/%0d exp=1/2", IRQ, irq_id); end
    bus_wr(2'd0, 32'h0);
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL maskwr_take got=%b exp=0", IRQ); end
    bus_rd(2'd2);
    total++; if (rd_data !== 32'h8000_0002) begin bad++; $display("FAIL maskwr_svc got=%h exp=80000002", rd_data); end
    bus_rd(2'd0);
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL maskwr_mask got=%h exp=0", rd_data); end
  endtask

  task automatic test_reset_svc();
    bus_wr(2'd0, 32'h5);
    src_irq = 4'b0010;
    tick();
    src_irq = 4'b0000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (IRQ !== 1'b0 || irq_id !== 3'd0 || rd_data !== 32'h0) begin bad++; $display("FAIL rst_out got=%b/%0d/%h exp=0/0/0", IRQ, irq_id, rd_data); end
    bus_rd(2'd0);
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL rst_mask got=%h exp=0", rd_data); end
    bus_rd(2'd1);
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL rst_pend got=%h exp=0", rd_data); end
    bus_rd(2'd2);
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL rst_status got=%h exp=0", rd_data); end
    pulse_eret();
    bus_rd(2'd2);
    total++; if (rd_data !== 32'h0 || IRQ !== 1'b0) begin bad++; $display("FAIL rst_eret got=%h/%b exp=0/0", rd_data, IRQ); end
    bus_rd(2'd3);
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reserved got=%h exp=0", rd_data); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_kernel_hold();
    test_w1c();
    test_reset_svc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Prioritising interrupt controller that feeds the IRQ input of the single-cycle control unit.
- Latches requests from N_SRC peripheral sources and masks them through memory-mapped registers.
- Arbitrates by fixed priority and raises IRQ while the CPU is in user mode (PCK=0).
- Tracks the in-service interrupt until the handler executes its return (jr $26), so only one interrupt is ever in flight.

Parameters:
- N_SRC, 4, number of interrupt sources (1..8); source 0 has the highest priority.
- ID_W, 3, width of irq_id; must satisfy 2^ID_W >= N_SRC.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- src_irq  input  N_SRC  raw request lines from peripherals, already synchronous to clk
- PCK  input  1  PC[31] kernel-mode bit from the CPU; 1 = kernel mode
- eret  input  1  one-cycle pulse when the kernel handler executes jr $26 (return to user)
- wr_en  input  1  bus write strobe
- rd_en  input  1  bus read strobe
- addr  input  2  register select: 0=MASK, 1=PEND, 2=STATUS, 3=reserved
- wr_data  input  32  bus write data
- rd_data  output  32  registered read data
- IRQ  output  1  interrupt request to the control unit
- irq_id  output  ID_W  index of the source being requested or serviced

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - IRQ=0, irq_id=0, rd_data=0.
  - MASK=0 (all sources disabled), PEND=0, edge-history register=0.
  - FSM enters IDLE.
  - Reset taken mid-service abandons the in-service interrupt without waiting for eret.
- Request capture:
  - A rising edge on src_irq[i] (src_irq[i]=1 while prev[i]=0) sets PEND[i] on the next edge.
  - PEND is sticky and is independent of MASK.
- Eligibility and arbitration:
  - eligible = PEND & MASK.
  - Winner is the lowest set index of eligible; it is computed combinationally each cycle.
- FSM states:
  - IDLE: if eligible≠0, go to REQ next edge; latch irq_id=winner; IRQ=1 registered, so latency from source edge to IRQ is 2 cycles.
  - REQ: IRQ=1, irq_id is held. The interrupt is taken in the first cycle with IRQ=1 and PCK=0 (the control unit selects PCSrc=100 in that cycle). On that edge: go to SVC, IRQ=0, clear PEND[irq_id].
  - REQ, re-arbitration: if the latched source becomes ineligible before being taken (masked or cleared by software), go to IDLE and drop IRQ on the next edge. irq_id does not re-arbitrate while in REQ.
  - SVC: IRQ=0, irq_id holds the in-service source. On eret=1, go to IDLE. New requests keep accumulating in PEND.
  - eret outside SVC is ignored.
- Register map:
  - MASK (addr 0): read/write; bits [N_SRC-1:0] are significant, upper bits read 0.
  - PEND (addr 1): write-1-to-clear. If a source edge and a W1C of the same bit land in the same cycle, the set wins.
  - STATUS (addr 2): read-only. {busy=SVC at bit 31, req=REQ at bit 30, zeros, irq_id in low bits}.
  - Reserved (addr 3): reads 0, writes ignored.
- Bus timing:
  - Writes take effect at the strobe edge.
  - rd_data is updated one cycle after rd_en and holds its value otherwise.
  - A read and a write to the same register in the same cycle return the old value.
- Simultaneous events:
  - A PEND set and a clear-on-take of the same bit in the same cycle: the set wins, because it is a new request.
  - A MASK write that disables the REQ source on the same edge the interrupt is taken: the take wins.

Optional Feature:
- Macro: IRQC_LEVEL_EN.
- Defined: sources are level-sensitive.
  - PEND[i] mirrors src_irq[i] registered each cycle.
  - PEND W1C writes are ignored.
  - The take does not clear PEND; the peripheral must drop its line before eret.
  - Edge-history register is removed.
- Undefined: edge-triggered sticky PEND, as described under Behaviour.

Test Plan:
- Reset, then MASK=0xF; pulse src_irq[2] with PCK=0 -> IRQ=1 and irq_id=2 two cycles after the edge; next edge IRQ=0, STATUS=0x80000002, PEND=0.
- src_irq[3] and src_irq[1] rise in the same cycle, MASK=0xF -> irq_id=1 served first; after eret, IRQ reasserts with irq_id=3.
- MASK=0x0, pulse src_irq[0] -> IRQ stays 0 and PEND=0x1; then write MASK=0x1 -> IRQ=1 two cycles later.
- IRQ=1 while PCK=1 for 5 cycles -> IRQ held, state REQ; PCK drops -> taken that cycle, SVC next edge.
- In REQ for source 2, write PEND=0x4 (W1C) -> IRQ=0 next edge, IDLE; same-cycle edge on src_irq[2] plus W1C -> PEND[2] stays 1.
- Assert reset while in SVC -> next edge all outputs 0, MASK=0, STATUS=0; a later eret pulse has no effect.
